// File: rtl/rfsoc_config_pkg.sv
// rfsoc_config: constants shared by the RFSoC sequencing blocks.
//   sched_state_e  - trigger scheduler state encoding (also driven on state_out)
//   ADDR_*         - scheduler register map addresses (delay[i] lives at i)
package rfsoc_config;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  localparam logic [7:0] ADDR_PERIOD = 8'h40;
  localparam logic [7:0] ADDR_REPEAT = 8'h41;
  localparam logic [7:0] ADDR_MASK   = 8'h42;

endpackage

// File: rtl/trig_sched_ch.sv
// trig_sched_ch: one DAC channel of the trigger scheduler.
// Holds the channel delay, compares it with the shared tick counter and
// registers a one-cycle trigger pulse.
// Build option TRIG_SCHED_BUSY_CHECK_EN: a hit while busy is high is
// suppressed and latched into the sticky err flag; otherwise busy is ignored
// and err is constant 0.
// Ports:
//   clk, rst          - clock, synchronous active-low reset
//   delay_we          - load delay_wdata into the delay register
//   tick, period      - shared sequencer tick counter and period
//   fire_en           - scheduler in RUN, no abort, channel enabled in mask
//   busy              - channel playback in progress
//   err_clr           - clear sticky busy-collision error
//   trig              - registered one-cycle trigger pulse
//   err               - sticky busy-collision error
module trig_sched_ch #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             delay_we,
  input  logic [CNT_W-1:0] delay_wdata,
  input  logic [CNT_W-1:0] tick,
  input  logic [CNT_W-1:0] period,
  input  logic             fire_en,
  input  logic             busy,
  input  logic             err_clr,
  output logic             trig,
  output logic             err
);

  logic [CNT_W-1:0] delay_q;
  logic             hit;

  // tick never reaches period, but the explicit guard keeps a channel whose
  // delay is out of range silent regardless of how tick is driven.
  assign hit = fire_en && (tick == delay_q) && (delay_q < period);

  always_ff @(posedge clk) begin
    if (!rst) begin
      delay_q <= '0;
    end else if (delay_we) begin
      delay_q <= delay_wdata;
    end
  end

`ifdef TRIG_SCHED_BUSY_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      trig <= 1'b0;
      err  <= 1'b0;
    end else begin
      trig <= hit && !busy;
      if (hit && busy) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end
`else
  logic unused_in;
  assign unused_in = busy ^ err_clr;
  assign err       = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      trig <= 1'b0;
    end else begin
      trig <= hit;
    end
  end
`endif

endmodule

// File: rtl/trig_sched.sv
// trig_sched: multi-channel DAC trigger sequencer.
// Registers (written only in IDLE): delay[i] at i, period 0x40, repeat 0x41,
// enable mask 0x42 (a mask write also clears err_out).
// Flow: IDLE -arm-> ARMED -start-> RUN -last wrap-> DONE -> IDLE.
// In RUN a tick counter runs 0..period-1; each wrap bumps the round counter.
// repeat==0 runs until abort. abort_in returns to IDLE from any state.
// Build option TRIG_SCHED_BUSY_CHECK_EN enables the per-channel busy check
// (see trig_sched_ch).
// Ports:
//   clk, rst                  - clock, synchronous active-low reset
//   cfg_wr/cfg_addr/cfg_wdata - register write port
//   arm_in, start_in, abort_in- sequencing controls
//   ch_busy                   - per-channel playback flags
//   trigger_out               - per-channel one-cycle trigger pulses
//   state_out                 - current FSM state (sched_state_e)
//   done_out                  - high for the single DONE cycle
//   err_out                   - [NUM_CH] config error, [NUM_CH-1:0] busy errors
module trig_sched
  import rfsoc_config::*;
#(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_wr,
  input  logic [7:0]        cfg_addr,
  input  logic [CNT_W-1:0]  cfg_wdata,
  input  logic              arm_in,
  input  logic              start_in,
  input  logic              abort_in,
  input  logic [NUM_CH-1:0] ch_busy,
  output logic [NUM_CH-1:0] trigger_out,
  output logic [1:0]        state_out,
  output logic              done_out,
  output logic [NUM_CH:0]   err_out
);

  sched_state_e      state_q, state_d;
  logic [CNT_W-1:0]  period_q, repeat_q, tick_q, round_q;
  logic [NUM_CH-1:0] mask_q, ch_err;
  logic              cfg_err_q, arm_err, cfg_ok, err_clr, wrap, run_fire;

  assign cfg_ok   = cfg_wr && (state_q == ST_IDLE);
  assign err_clr  = cfg_ok && (cfg_addr == ADDR_MASK);
  assign wrap     = (tick_q == period_q - CNT_W'(1));
  assign run_fire = (state_q == ST_RUN) && !abort_in;

  // Next-state logic; abort has priority over every other control.
  always_comb begin
    state_d = state_q;
    arm_err = 1'b0;
    if (abort_in) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm_in) begin
            if ((period_q != '0) && (mask_q != '0)) state_d = ST_ARMED;
            else                                    arm_err = 1'b1;
          end
        end
        ST_ARMED: if (start_in) state_d = ST_RUN;
        ST_RUN: begin
          if (wrap && (repeat_q != '0) && (round_q == repeat_q - CNT_W'(1)))
            state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      tick_q    <= '0;
      round_q   <= '0;
      period_q  <= '0;
      repeat_q  <= CNT_W'(1);
      mask_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Counters sit at 0 outside RUN, so the ARMED->RUN edge starts at 0.
      if (state_q != ST_RUN) begin
        tick_q  <= '0;
        round_q <= '0;
      end else if (wrap) begin
        tick_q  <= '0;
        round_q <= round_q + CNT_W'(1);
      end else begin
        tick_q  <= tick_q + CNT_W'(1);
      end
      if (cfg_ok && (cfg_addr == ADDR_PERIOD)) period_q <= cfg_wdata;
      if (cfg_ok && (cfg_addr == ADDR_REPEAT)) repeat_q <= cfg_wdata;
      if (cfg_ok && (cfg_addr == ADDR_MASK))   mask_q   <= cfg_wdata[NUM_CH-1:0];
      if (arm_err)      cfg_err_q <= 1'b1;
      else if (err_clr) cfg_err_q <= 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    trig_sched_ch #(.CNT_W(CNT_W)) u_ch (
      .clk         (clk),
      .rst         (rst),
      .delay_we    (cfg_ok && (cfg_addr == 8'(i))),
      .delay_wdata (cfg_wdata),
      .tick        (tick_q),
      .period      (period_q),
      .fire_en     (run_fire && mask_q[i]),
      .busy        (ch_busy[i]),
      .err_clr     (err_clr),
      .trig        (trigger_out[i]),
      .err         (ch_err[i])
    );
  end

  assign state_out = state_q;
  assign done_out  = (state_q == ST_DONE);
  assign err_out   = {cfg_err_q, ch_err};

endmodule

// File: tb/tb_trig_sched.sv
// tb_trig_sched: directed bench for trig_sched (NUM_CH=8, CNT_W=16).
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_trig_sched;

  localparam int NUM_CH = 8;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_wr;
  logic [7:0]        cfg_addr;
  logic [CNT_W-1:0]  cfg_wdata;
  logic              arm_in, start_in, abort_in;
  logic [NUM_CH-1:0] ch_busy;
  logic [NUM_CH-1:0] trigger_out;
  logic [1:0]        state_out;
  logic              done_out;
  logic [NUM_CH:0]   err_out;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- clock / reset ----------------
  always #2 clk = ~clk;

  trig_sched #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_wr      (cfg_wr),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .arm_in      (arm_in),
    .start_in    (start_in),
    .abort_in    (abort_in),
    .ch_busy     (ch_busy),
    .trigger_out (trigger_out),
    .state_out   (state_out),
    .done_out    (done_out),
    .err_out     (err_out)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [CNT_W-1:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_wr = 1'b0;
  endtask

  task automatic do_arm();
    arm_in = 1'b1;
    step();
    arm_in = 1'b0;
  endtask

  task automatic do_start();
    start_in = 1'b1;
    step();
    start_in = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  logic [NUM_CH-1:0] exp_trig;
  logic [NUM_CH:0]   exp_err;

  initial begin
    rst = 1'b0; cfg_wr = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    arm_in = 1'b0; start_in = 1'b0; abort_in = 1'b0; ch_busy = '0;
    step(); step(); step();

    // ---- reset state ----
    check("rst_state", 32'(state_out), 32'd0);
    check("rst_trig",  32'(trigger_out), 32'd0);
    check("rst_done",  32'(done_out), 32'd0);
    check("rst_err",   32'(err_out), 32'd0);
    rst = 1'b1;
    step();

    // ---- two-channel, two-round run ----
    cfg_write(8'h00, 16'd0);
    cfg_write(8'h01, 16'd4);
    cfg_write(8'h40, 16'd10);
    cfg_write(8'h41, 16'd2);
    cfg_write(8'h42, 16'h0003);
    do_arm();
    check("arm_state", 32'(state_out), 32'd1);
    do_start();
    for (int k = 0; k < 25; k++) begin
      exp_trig = '0;
      if (k == 1 || k == 11) exp_trig[0] = 1'b1;
      if (k == 5 || k == 15) exp_trig[1] = 1'b1;
      check($sformatf("run1_trig_k%0d", k), 32'(trigger_out), 32'(exp_trig));
      check($sformatf("run1_done_k%0d", k), 32'(done_out), (k == 20) ? 32'd1 : 32'd0);
      check($sformatf("run1_state_k%0d", k), 32'(state_out),
            (k < 20) ? 32'd2 : ((k == 20) ? 32'd3 : 32'd0));
      step();
    end

    // ---- delay equal to period never fires ----
    cfg_write(8'h02, 16'd10);
    cfg_write(8'h42, 16'h0004);
    do_arm();
    do_start();
    for (int k = 0; k < 25; k++) begin
      check($sformatf("oob_trig_k%0d", k), 32'(trigger_out), 32'd0);
      check($sformatf("oob_done_k%0d", k), 32'(done_out), (k == 20) ? 32'd1 : 32'd0);
      step();
    end

    // ---- arm with period 0 is rejected ----
    cfg_write(8'h40, 16'd0);
    do_arm();
    check("cfgerr_state", 32'(state_out), 32'd0);
    check("cfgerr_err",   32'(err_out), 32'h100);
    step();
    check("cfgerr_hold",  32'(state_out), 32'd0);
    cfg_write(8'h42, 16'h0004);
    check("cfgerr_clr",   32'(err_out), 32'd0);

    // ---- free-running with abort after 23 cycles ----
    cfg_write(8'h40, 16'd5);
    cfg_write(8'h41, 16'd0);
    cfg_write(8'h42, 16'h0001);
    do_arm();
    do_start();
    for (int k = 0; k < 23; k++) begin
      exp_trig = '0;
      if (k >= 1 && (k % 5) == 1) exp_trig[0] = 1'b1;
      check($sformatf("free_trig_k%0d", k), 32'(trigger_out), 32'(exp_trig));
      check($sformatf("free_done_k%0d", k), 32'(done_out), 32'd0);
      step();
    end
    check("free_state_k23", 32'(state_out), 32'd2);
    abort_in = 1'b1;
    step();
    abort_in = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("abort_trig_%0d", k),  32'(trigger_out), 32'd0);
      check($sformatf("abort_state_%0d", k), 32'(state_out), 32'd0);
      check($sformatf("abort_done_%0d", k),  32'(done_out), 32'd0);
      step();
    end

    // ---- busy collision on channel 0 ----
    cfg_write(8'h41, 16'd1);
    do_arm();
    do_start();
    ch_busy = 8'h01;
    step();
    ch_busy = '0;
`ifdef TRIG_SCHED_BUSY_CHECK_EN
    exp_trig = '0;
    exp_err  = 9'h001;
`else
    exp_trig = 8'h01;
    exp_err  = 9'h000;
`endif
    check("busy_trig", 32'(trigger_out), 32'(exp_trig));
    check("busy_err",  32'(err_out), 32'(exp_err));
    step(); step(); step();
    check("busy_pre_done", 32'(done_out), 32'd0);
    step();
    check("busy_done", 32'(done_out), 32'd1);
    check("busy_err_sticky", 32'(err_out), 32'(exp_err));
    step();
    cfg_write(8'h42, 16'h0003);
    check("busy_err_clr", 32'(err_out), 32'd0);

    // ---- reset in the middle of a run ----
    cfg_write(8'h40, 16'd10);
    cfg_write(8'h41, 16'd2);
    do_arm();
    do_start();
    step(); step(); step();
    check("midrst_running", 32'(state_out), 32'd2);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("midrst_trig",  32'(trigger_out), 32'd0);
    check("midrst_state", 32'(state_out), 32'd0);
    check("midrst_done",  32'(done_out), 32'd0);
    check("midrst_err",   32'(err_out), 32'd0);
    for (int k = 0; k < 12; k++) begin
      check($sformatf("midrst_quiet_%0d", k), 32'(trigger_out), 32'd0);
      step();
    end
    do_arm();
    check("rearm_state", 32'(state_out), 32'd0);
    check("rearm_err",   32'(err_out), 32'h100);

    // ---- final report ----
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
